chacha20_block_controller: RTL and testbench

Sequences the serial ChaCha20 round datapath to produce 512-bit keystream blocks. The block captures key, nonce and initial block counter on `start`, builds the initial state and loads it into `chacha20_serial_encoder`, and waits out the round latency. It then adds the initial state back and presents each keystream block on a valid/ready interface. Consecutive blocks use an incremented counter. It sits between the cipher front-end (key/nonce source, XOR stage) and the round datapath.

---
 rtl/chacha20_pkg.sv | 38 +++
 rtl/chacha20_block_controller_state_add.sv | 15 +
 rtl/chacha20_block_controller.sv | 144 ++++++++++++++
 tb/tb_chacha20_block_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 definitions: sigma constants, state-word layout, controller
// FSM encoding and the initial-state packing function.
package chacha20_pkg;

    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;

    localparam int IDX_SIGMA0 = 0;
    localparam int IDX_KEY0   = 4;
    localparam int IDX_CTR    = 12;
    localparam int IDX_NONCE0 = 13;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_ADD    = 3'd3,
        ST_OUTPUT = 3'd4
    } ctrl_state_e;

    function automatic logic [511:0] pack_state(input logic [255:0] key,
                                                input logic [31:0]  counter,
                                                input logic [95:0]  nonce);
        logic [511:0] s;
        s = '0;
        s[32*IDX_SIGMA0      +: 32]  = SIGMA0;
        s[32*(IDX_SIGMA0+1)  +: 32]  = SIGMA1;
        s[32*(IDX_SIGMA0+2)  +: 32]  = SIGMA2;
        s[32*(IDX_SIGMA0+3)  +: 32]  = SIGMA3;
        s[32*IDX_KEY0        +: 256] = key;
        s[32*IDX_CTR         +: 32]  = counter;
        s[32*IDX_NONCE0      +: 96]  = nonce;
        return s;
    endfunction

endpackage

// File: rtl/chacha20_block_controller_state_add.sv
// Final ChaCha20 feed-forward: sixteen independent 32-bit lane additions,
// no carry crossing a word boundary.
module chacha20_state_add
    import chacha20_pkg::*;
(
    input  logic [511:0] round_i,
    input  logic [511:0] init_i,
    output logic [511:0] sum_o
);

    for (genvar i = 0; i < 16; i++) begin : g_lane
        assign sum_o[32*i +: 32] = round_i[32*i +: 32] + init_i[32*i +: 32];
    end

endmodule

// File: rtl/chacha20_block_controller.sv
// Sequences the serial ChaCha20 round datapath: load initial state, wait out
// the round latency, add the state back and present keystream blocks.
module chacha20_block_controller
    import chacha20_pkg::*;
#(
    parameter int ROUND_CYCLES = 80
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  initial_counter,
    input  logic [15:0]  num_blocks,
    input  logic         out_ready,
    input  logic [511:0] enc_round_output,
    output logic [511:0] enc_round_input,
    output logic         enc_set_state,
    output logic [511:0] keystream,
    output logic         keystream_valid,
    output logic         busy,
    output logic [31:0]  block_counter,
    output logic         counter_overflow
);

    localparam int RCW = $clog2(ROUND_CYCLES + 1);
    localparam logic [RCW-1:0] RC_LAST = RCW'(ROUND_CYCLES - 1);

    ctrl_state_e    state_q, state_d;
    logic [255:0]   key_q, key_d;
    logic [95:0]    nonce_q, nonce_d;
    logic [31:0]    counter_q, counter_d;
    logic [15:0]    remaining_q, remaining_d;
    logic [RCW-1:0] round_cnt_q, round_cnt_d;
    logic [511:0]   keystream_q, keystream_d;
    logic           overflow_q, overflow_d;

    logic [511:0]   init_state;
    logic [511:0]   block_sum;

    assign init_state = pack_state(key_q, counter_q, nonce_q);

    chacha20_state_add u_state_add (
        .round_i (enc_round_output),
        .init_i  (init_state),
        .sum_o   (block_sum)
    );

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        nonce_d     = nonce_q;
        counter_d   = counter_q;
        remaining_d = remaining_q;
        round_cnt_d = round_cnt_q;
        keystream_d = keystream_q;
        overflow_d  = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d       = key;
                    nonce_d     = nonce;
                    counter_d   = initial_counter;
                    // remaining counts blocks still owed after the current one
                    remaining_d = (num_blocks == 16'd0) ? 16'd0 : num_blocks - 16'd1;
                    overflow_d  = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                round_cnt_d = RC_LAST;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (round_cnt_q == '0) begin
                    state_d = ST_ADD;
                end else begin
                    round_cnt_d = round_cnt_q - 1'b1;
                end
            end
            ST_ADD: begin
                keystream_d = block_sum;
                state_d     = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    if (remaining_q == 16'd0) begin
                        state_d = ST_IDLE;
                    end else if (counter_q == 32'hFFFF_FFFF) begin
                        overflow_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        counter_d   = counter_q + 32'd1;
                        remaining_d = remaining_q - 16'd1;
                        state_d     = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            nonce_q     <= '0;
            counter_q   <= '0;
            remaining_q <= '0;
            round_cnt_q <= '0;
            keystream_q <= '0;
            overflow_q  <= 1'b0;
        end else if (clear) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            nonce_q     <= '0;
            counter_q   <= '0;
            remaining_q <= '0;
            round_cnt_q <= '0;
            keystream_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            nonce_q     <= nonce_d;
            counter_q   <= counter_d;
            remaining_q <= remaining_d;
            round_cnt_q <= round_cnt_d;
            keystream_q <= keystream_d;
            overflow_q  <= overflow_d;
        end
    end

    assign enc_round_input  = init_state;
    assign enc_set_state    = (state_q == ST_LOAD);
    assign keystream        = keystream_q;
    assign keystream_valid  = (state_q == ST_OUTPUT);
    assign busy             = (state_q != ST_IDLE);
    assign block_counter    = counter_q;
    assign counter_overflow = overflow_q;

endmodule

// File: tb/tb_chacha20_block_controller.sv
// Directed bench for chacha20_block_controller with a behavioural round-datapath
// stand-in and an independent ChaCha20 block reference.
module tb_chacha20_block_controller;

    localparam int RC = 80;

    logic         clock = 1'b0;
    logic         reset, clear, start, out_ready;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  initial_counter;
    logic [15:0]  num_blocks;
    logic [511:0] enc_round_output, enc_round_input, keystream;
    logic         enc_set_state, keystream_valid, busy, counter_overflow;
    logic [31:0]  block_counter;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;

    chacha20_block_controller #(.ROUND_CYCLES(RC)) dut (
        .clock            (clock),
        .reset            (reset),
        .clear            (clear),
        .start            (start),
        .key              (key),
        .nonce            (nonce),
        .initial_counter  (initial_counter),
        .num_blocks       (num_blocks),
        .out_ready        (out_ready),
        .enc_round_output (enc_round_output),
        .enc_round_input  (enc_round_input),
        .enc_set_state    (enc_set_state),
        .keystream        (keystream),
        .keystream_valid  (keystream_valid),
        .busy             (busy),
        .block_counter    (block_counter),
        .counter_overflow (counter_overflow)
    );

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a0, input logic [31:0] b0,
                                        input logic [31:0] c0, input logic [31:0] d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha_rounds(input logic [511:0] s);
        logic [31:0]  x [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        for (int k = 0; k < 10; k++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i];
        return r;
    endfunction

    function automatic logic [511:0] ref_state(input logic [255:0] k, input logic [31:0] c,
                                               input logic [95:0] n);
        logic [31:0]  w [16];
        logic [511:0] s;
        w[0] = 32'h61707865; w[1] = 32'h3320646e; w[2] = 32'h79622d32; w[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) w[4+i] = k[32*i +: 32];
        w[12] = c;
        for (int i = 0; i < 3; i++) w[13+i] = n[32*i +: 32];
        for (int i = 0; i < 16; i++) s[32*i +: 32] = w[i];
        return s;
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [31:0] c,
                                               input logic [95:0] n);
        logic [511:0] s, r, o;
        s = ref_state(k, c, n);
        r = chacha_rounds(s);
        for (int i = 0; i < 16; i++) o[32*i +: 32] = r[32*i +: 32] + s[32*i +: 32];
        return o;
    endfunction

    // Stand-in for the serial encoder: result only appears RC clocks after load.
    logic [511:0] enc_st  = '0;
    int           enc_cnt = 1000;
    logic [511:0] enc_res;

    always @(posedge clock) begin
        if (enc_set_state) begin
            enc_st  <= enc_round_input;
            enc_cnt <= 0;
        end else if (enc_cnt < 1000) begin
            enc_cnt <= enc_cnt + 1;
        end
    end

    always_comb enc_res = chacha_rounds(enc_st);
    assign enc_round_output = (enc_cnt >= RC) ? enc_res : ~enc_st;

    task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int waited;
        waited = 0;
        while (!keystream_valid && waited < bound) begin
            tick();
            waited++;
        end
        check_eq(tag, keystream_valid, 1'b1);
    endtask

    task automatic do_start(input logic [31:0] ctr, input logic [15:0] nb);
        initial_counter = ctr;
        num_blocks      = nb;
        start           = 1'b1;
        tick();
        start           = 1'b0;
    endtask

    int           t0, t_prev, n_v;
    logic [255:0] key_b;
    logic [95:0]  nonce_b;

    initial begin
        reset = 1'b1; clear = 1'b0; start = 1'b0; out_ready = 1'b0;
        key = '0; nonce = '0; initial_counter = '0; num_blocks = '0;
        for (int b = 0; b < 32; b++) key[8*b +: 8] = 8'(b);
        nonce[31:0] = 32'h09000000; nonce[63:32] = 32'h4a000000; nonce[95:64] = 32'h0;
        key_b   = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hfeedface,
                   32'h0badf00d, 32'hcafebabe, 32'h13579bdf, 32'h2468ace0};
        nonce_b = {32'h11223344, 32'h55667788, 32'h99aabbcc};
        tick(); tick();
        reset = 1'b0;
        tick();

        check_eq("rst_keystream", keystream, '0);
        check_eq("rst_valid", keystream_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_counter", block_counter, 32'd0);
        check_eq("rst_overflow", counter_overflow, 1'b0);
        check_eq("rst_set_state", enc_set_state, 1'b0);

        // RFC 8439 block with held-off consumer
        t0 = cyc;
        do_start(32'd1, 16'd1);
        key = '1; nonce = '1;
        check_eq("rfc_load_set", enc_set_state, 1'b1);
        for (int b = 0; b < 32; b++) key_b[8*b +: 8] = key_b[8*b +: 8];
        wait_valid("rfc_valid", 200);
        check_eq("rfc_latency", 32'(cyc - t0), 32'(RC + 3));
        check_eq("rfc_word0", keystream[31:0], 32'he4e7f110);
        check_eq("rfc_word15", keystream[511:480], 32'h4e3c50a2);
        check_eq("rfc_counter", block_counter, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("hold_valid", keystream_valid, 1'b1);
            check_eq("hold_word0", keystream[31:0], 32'he4e7f110);
            check_eq("hold_no_load", enc_set_state, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        check_eq("rfc_valid_drop", keystream_valid, 1'b0);
        check_eq("rfc_busy_done", busy, 1'b0);

        // Three back-to-back blocks from counter 5
        key = key_b; nonce = nonce_b;
        do_start(32'd5, 16'd3);
        key = '0; nonce = '0;
        check_eq("multi_load_state", enc_round_input, ref_state(key_b, 32'd5, nonce_b));
        t_prev = 0;
        for (int b = 0; b < 3; b++) begin
            wait_valid("multi_valid", 200);
            check_eq("multi_counter", block_counter, 32'(5 + b));
            check_eq("multi_block", keystream, ref_block(key_b, 32'(5 + b), nonce_b));
            if (b > 0) check_eq("multi_spacing", 32'(cyc - t_prev), 32'(RC + 3));
            t_prev = cyc;
            tick();
        end
        check_eq("multi_busy_done", busy, 1'b0);

        // Counter at 0xFFFFFFFF with a second block requested
        key = key_b; nonce = nonce_b;
        do_start(32'hFFFF_FFFF, 16'd2);
        wait_valid("ovf_valid", 200);
        check_eq("ovf_block", keystream, ref_block(key_b, 32'hFFFF_FFFF, nonce_b));
        tick();
        check_eq("ovf_flag", counter_overflow, 1'b1);
        check_eq("ovf_busy", busy, 1'b0);
        check_eq("ovf_counter_no_wrap", block_counter, 32'hFFFF_FFFF);
        repeat (5) tick();
        check_eq("ovf_stays_idle", busy, 1'b0);
        check_eq("ovf_sticky", counter_overflow, 1'b1);
        do_start(32'd0, 16'd1);
        check_eq("ovf_cleared_by_start", counter_overflow, 1'b0);
        wait_valid("ovf_restart_valid", 200);
        check_eq("ovf_restart_block", keystream, ref_block(key_b, 32'd0, nonce_b));
        tick();

        // start pulsed mid-RUN is ignored
        do_start(32'd20, 16'd2);
        n_v = 0;
        for (int i = 0; i < 2 * (RC + 3) + 60; i++) begin
            if (i == 20) start = 1'b1;
            if (i == 21) start = 1'b0;
            if (keystream_valid) n_v++;
            tick();
        end
        check_eq("ignore_start_blocks", 32'(n_v), 32'd2);
        check_eq("ignore_start_idle", busy, 1'b0);

        // Asynchronous reset in the middle of RUN
        out_ready = 1'b0;
        do_start(32'd7, 16'd1);
        repeat (30) tick();
        #2;
        reset = 1'b1;
        #1;
        check_eq("areset_keystream", keystream, '0);
        check_eq("areset_busy", busy, 1'b0);
        check_eq("areset_counter", block_counter, 32'd0);
        check_eq("areset_valid", keystream_valid, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        do_start(32'd9, 16'd0);
        wait_valid("areset_fresh_valid", 200);
        check_eq("areset_fresh_block", keystream, ref_block(key_b, 32'd9, nonce_b));
        out_ready = 1'b1;
        tick();
        check_eq("zero_blocks_as_one", busy, 1'b0);

        // Synchronous clear in the middle of RUN
        do_start(32'd3, 16'd1);
        repeat (30) tick();
        clear = 1'b1;
        check_eq("clear_before_edge", busy, 1'b1);
        tick();
        clear = 1'b0;
        check_eq("clear_busy", busy, 1'b0);
        check_eq("clear_counter", block_counter, 32'd0);
        check_eq("clear_keystream", keystream, '0);
        clear = 1'b1;
        do_start(32'd4, 16'd1);
        clear = 1'b0;
        check_eq("clear_beats_start", busy, 1'b0);
        check_eq("clear_beats_start_load", enc_set_state, 1'b0);
        do_start(32'd11, 16'd1);
        wait_valid("clear_fresh_valid", 200);
        check_eq("clear_fresh_block", keystream, ref_block(key_b, 32'd11, nonce_b));
        tick();
        check_eq("clear_fresh_done", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
